// File: rtl/fb_bus_arbiter.sv
// Two-port burst arbiter sharing one Wishbone framebuffer port between
// display line fetch (port 0) and frame writer (port 1).
module fb_bus_arbiter #(
   parameter int unsigned AW           = 24,
   parameter int unsigned DW           = 32,
   parameter int unsigned LW           = 8,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          pixel_clk,
   input  logic          pixel_rst_n,
   input  logic          req0_valid,
   input  logic          req0_urgent,
   input  logic [AW-1:0] req0_adr,
   input  logic [LW-1:0] req0_len,
   input  logic          req0_we,
   input  logic [DW-1:0] req0_wdat,
   output logic          req0_gnt,
   output logic          req0_ack,
   output logic          req0_done,
   output logic          req0_err,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_adr,
   input  logic [LW-1:0] req1_len,
   input  logic          req1_we,
   input  logic [DW-1:0] req1_wdat,
   output logic          req1_gnt,
   output logic          req1_ack,
   output logic          req1_done,
   output logic          req1_err,
   output logic [DW-1:0] rdat,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   output logic [AW-1:0] wb_adr,
   output logic [DW-1:0] wb_dat_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RELEASE
   } state_t;

   state_t        state_q;
   logic          owner_q;
   logic          last_owner_q;
   logic [AW-1:0] adr_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] beat_q;
   logic          we_q;
   logic [TW-1:0] tmo_q;
   logic [SW-1:0] starve_q;
   logic          cyc_q;
   logic [1:0]    gnt_q;
   logic [1:0]    ack_q;
   logic [1:0]    done_q;
   logic [1:0]    err_q;
   logic [DW-1:0] rdat_q;

   logic [AW-1:0] adr_d;
   logic [LW-1:0] beat_d;
   logic [TW-1:0] tmo_d;
   logic [SW-1:0] starve_d;
   logic          starve_full;
   logic          last_beat;
   logic          tmo_hit;
   logic          pick_vld;
   logic          pick_port;
   logic          pick_urg;
   logic [AW-1:0] pick_adr;
   logic [LW-1:0] pick_len;
   logic          pick_we;

   // Owner selection: starvation guard, then urgent display, then round-robin.
   always_comb begin
      pick_vld  = 1'b0;
      pick_port = 1'b0;
      pick_urg  = 1'b0;
      if (req1_valid && starve_full) begin
         pick_vld  = 1'b1;
         pick_port = 1'b1;
      end else if (req0_valid && req0_urgent) begin
         pick_vld  = 1'b1;
         pick_urg  = 1'b1;
      end else if (req0_valid && req1_valid) begin
         pick_vld  = 1'b1;
         pick_port = ~last_owner_q;
      end else if (req0_valid) begin
         pick_vld  = 1'b1;
      end else if (req1_valid) begin
         pick_vld  = 1'b1;
         pick_port = 1'b1;
      end
   end

   assign pick_adr    = pick_port ? req1_adr : req0_adr;
   assign pick_len    = pick_port ? req1_len : req0_len;
   assign pick_we     = pick_port ? req1_we  : req0_we;
   assign adr_d       = adr_q + AW'(1);
   assign beat_d      = beat_q + LW'(1);
   assign tmo_d       = tmo_q + TW'(1);
   assign starve_full = (starve_q == SW'(STARVE_LIMIT));
   assign starve_d    = starve_full ? starve_q : starve_q + SW'(1);
   assign last_beat   = (beat_q == len_q);
   assign tmo_hit     = (tmo_d == TW'(TIMEOUT));

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         adr_q        <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         we_q         <= 1'b0;
         tmo_q        <= '0;
         starve_q     <= '0;
         cyc_q        <= 1'b0;
         gnt_q        <= '0;
         ack_q        <= '0;
         done_q       <= '0;
         err_q        <= '0;
         rdat_q       <= '0;
      end else begin
         ack_q  <= '0;
         done_q <= '0;
         err_q  <= '0;
         if (!req1_valid) starve_q <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  state_q <= ST_BUSY;
                  owner_q <= pick_port;
                  adr_q   <= pick_adr;
                  len_q   <= pick_len;
                  we_q    <= pick_we;
                  beat_q  <= '0;
                  tmo_q   <= '0;
                  cyc_q   <= 1'b1;
                  gnt_q   <= pick_port ? 2'b10 : 2'b01;
                  if (pick_port) starve_q <= '0;
                  else if (pick_urg && req1_valid) starve_q <= starve_d;
               end
            end
            ST_BUSY: begin
               if (wb_ack) begin
                  rdat_q           <= wb_dat_i;
                  ack_q[owner_q]   <= 1'b1;
                  beat_q           <= beat_d;
                  adr_q            <= adr_d;
                  tmo_q            <= '0;
                  if (last_beat) begin
                     done_q[owner_q] <= 1'b1;
                     cyc_q           <= 1'b0;
                     gnt_q           <= '0;
                     last_owner_q    <= owner_q;
                     state_q         <= ST_RELEASE;
                  end
               end else if (tmo_hit) begin
                  // Slave never answered: abandon the burst so the bus cannot lock up.
                  err_q[owner_q] <= 1'b1;
                  cyc_q          <= 1'b0;
                  gnt_q          <= '0;
                  state_q        <= ST_RELEASE;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            ST_RELEASE: state_q <= ST_IDLE;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   assign req0_gnt  = gnt_q[0];
   assign req1_gnt  = gnt_q[1];
   assign req0_ack  = ack_q[0];
   assign req1_ack  = ack_q[1];
   assign req0_done = done_q[0];
   assign req1_done = done_q[1];
   assign req0_err  = err_q[0];
   assign req1_err  = err_q[1];
   assign rdat      = rdat_q;
   assign wb_cyc    = cyc_q;
   assign wb_stb    = cyc_q;
   assign wb_we     = cyc_q & we_q;
   assign wb_adr    = cyc_q ? adr_q : '0;
   // Write data passes straight through from the owner so each beat sees current data.
   assign wb_dat_o  = cyc_q ? (owner_q ? req1_wdat : req0_wdat) : '0;

endmodule

// File: tb/tb_fb_bus_arbiter.sv
// Directed scoreboard bench for fb_bus_arbiter: requester/slave models, expected
// beats queued at stimulus time and checked at bus and requester sides.
module tb_fb_bus_arbiter;
   localparam int unsigned AW = 24;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;

   logic          pixel_clk   = 1'b0;
   logic          pixel_rst_n = 1'b0;
   logic          req0_valid = 1'b0, req0_urgent = 1'b0, req0_we = 1'b0;
   logic          req1_valid = 1'b0, req1_we = 1'b0;
   logic [AW-1:0] req0_adr = '0, req1_adr = '0;
   logic [LW-1:0] req0_len = '0, req1_len = '0;
   logic [DW-1:0] req0_wdat = '0, req1_wdat = '0;
   logic          req0_gnt, req0_ack, req0_done, req0_err;
   logic          req1_gnt, req1_ack, req1_done, req1_err;
   logic [DW-1:0] rdat, wb_dat_o;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_dat_i = '0;
   logic          wb_ack   = 1'b0;

   fb_bus_arbiter #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(255), .STARVE_LIMIT(4)) dut (
      .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
      .req0_valid(req0_valid), .req0_urgent(req0_urgent), .req0_adr(req0_adr),
      .req0_len(req0_len), .req0_we(req0_we), .req0_wdat(req0_wdat),
      .req0_gnt(req0_gnt), .req0_ack(req0_ack), .req0_done(req0_done), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_len(req1_len),
      .req1_we(req1_we), .req1_wdat(req1_wdat),
      .req1_gnt(req1_gnt), .req1_ack(req1_ack), .req1_done(req1_done), .req1_err(req1_err),
      .rdat(rdat), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic [AW-1:0] adr;
      logic [LW-1:0] len;
      logic          we;
      logic [DW-1:0] wbase;
   } burst_t;
   typedef struct {
      int            port;
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] wdat;
      bit            last;
   } beat_t;
   typedef struct {
      int            port;
      logic [DW-1:0] rdat;
      bit            last;
   } ackexp_t;

   burst_t  rq0[$];
   burst_t  rq1[$];
   beat_t   exp_q[$];
   ackexp_t ack_q[$];

   int checks = 0;
   int errors = 0;
   int bi0 = 0, bi1 = 0;
   int sw = 0;
   bit sfirst = 1'b1;
   int slv_lat = 2, slv_gap = 0;
   bit slv_en = 1'b1;
   int cyc_n = 0;
   int g0_run = 0, g0_len = 0, g0_rise = 0;
   bit g0_prev = 1'b0;
   int err0_cnt = 0, err0_cyc = 0;
   logic err0_wbcyc = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] rd_func(input logic [AW-1:0] a);
      return {8'hA5, a} ^ 32'h1357_9BDF;
   endfunction

   task automatic push_burst(input int port, input logic [AW-1:0] adr, input logic [LW-1:0] len,
                             input logic we, input logic [DW-1:0] wbase, input bit beats);
      burst_t b;
      beat_t  e;
      b.adr = adr; b.len = len; b.we = we; b.wbase = wbase;
      if (port == 0) rq0.push_back(b);
      else rq1.push_back(b);
      if (beats) begin
         for (int i = 0; i <= int'(len); i++) begin
            e.port = port;
            e.adr  = AW'(adr + AW'(i));
            e.we   = we;
            e.wdat = wbase + DW'(i);
            e.last = (i == int'(len));
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || ack_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || wb_cyc)
             && n < limit) begin
         @(negedge pixel_clk);
         n++;
      end
      chk({tag, "_drain"}, 64'(n < limit), 64'(1));
      repeat (3) @(negedge pixel_clk);
   endtask

   // Requester models: hold valid while bursts remain, advance write data per ack.
   always @(posedge pixel_clk) begin
      #1;
      if (!pixel_rst_n) begin bi0 = 0; bi1 = 0; end
      if (req0_done || req0_err) begin
         if (rq0.size() != 0) rq0.delete(0);
         bi0 = 0;
      end else if (req0_ack) bi0++;
      if (req1_done || req1_err) begin
         if (rq1.size() != 0) rq1.delete(0);
         bi1 = 0;
      end else if (req1_ack) bi1++;
      req0_valid = (rq0.size() != 0);
      if (req0_valid) begin
         req0_adr = rq0[0].adr; req0_len = rq0[0].len; req0_we = rq0[0].we;
         req0_wdat = rq0[0].wbase + DW'(bi0);
      end
      req1_valid = (rq1.size() != 0);
      if (req1_valid) begin
         req1_adr = rq1[0].adr; req1_len = rq1[0].len; req1_we = rq1[0].we;
         req1_wdat = rq1[0].wbase + DW'(bi1);
      end
   end

   // Slave model: first ack after slv_lat cycles of strobe, later acks every slv_gap.
   always @(negedge pixel_clk) begin
      beat_t   e;
      ackexp_t a;
      if (!(wb_cyc && wb_stb)) begin
         wb_ack = 1'b0; sw = 0; sfirst = 1'b1;
      end else begin
         if (wb_ack) begin sw = 0; sfirst = 1'b0; end
         else sw++;
         wb_ack = slv_en && (sw >= (sfirst ? slv_lat : slv_gap));
         if (wb_ack) begin
            wb_dat_i = rd_func(wb_adr);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_gnt", 64'({req1_gnt, req0_gnt}), 64'(e.port != 0 ? 2 : 1));
               chk("beat_adr", 64'(wb_adr), 64'(e.adr));
               chk("beat_we", 64'(wb_we), 64'(e.we));
               if (e.we) chk("beat_wdat", 64'(wb_dat_o), 64'(e.wdat));
               a.port = e.port; a.rdat = rd_func(e.adr); a.last = e.last;
               ack_q.push_back(a);
            end
         end
      end
   end

   // Requester-side monitor: ack/done/rdat against scoreboard, grant length, timeout.
   always @(posedge pixel_clk) begin
      ackexp_t a;
      #1;
      cyc_n++;
      if (req0_ack || req1_ack) begin
         chk("ack_expected", 64'(ack_q.size() != 0), 64'(1));
         if (ack_q.size() != 0) begin
            a = ack_q.pop_front();
            chk("ack_port", 64'({req1_ack, req0_ack}), 64'(a.port != 0 ? 2 : 1));
            chk("ack_rdat", 64'(rdat), 64'(a.rdat));
            chk("ack_done", 64'({req1_done, req0_done}), 64'(a.last ? (a.port != 0 ? 2 : 1) : 0));
         end
      end else if (req0_done || req1_done) begin
         chk("done_without_ack", 64'({req1_done, req0_done}), 64'(0));
      end
      if (req0_gnt) begin
         if (!g0_prev) g0_rise = cyc_n;
         g0_run++;
      end else if (g0_run != 0) begin
         g0_len = g0_run;
         g0_run = 0;
      end
      g0_prev = req0_gnt;
      if (req0_err) begin
         err0_cnt++;
         err0_cyc   = cyc_n - g0_rise;
         err0_wbcyc = wb_cyc;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge pixel_clk);
      chk("rst_gnt", 64'({req1_gnt, req0_gnt}), 64'(0));
      chk("rst_bus", 64'({wb_cyc, wb_stb, wb_we}), 64'(0));
      chk("rst_adr", 64'(wb_adr), 64'(0));
      chk("rst_pulses", 64'({req1_ack, req0_ack, req1_done, req0_done, req1_err, req0_err}), 64'(0));
      chk("rst_rdat", 64'(rdat), 64'(0));
      chk("rst_dat_o", 64'(wb_dat_o), 64'(0));
      pixel_rst_n = 1'b1;
      repeat (4) @(negedge pixel_clk);
      chk("idle_no_req", 64'({req1_gnt, req0_gnt, wb_cyc}), 64'(0));

      // Round-robin: both ports busy, grants alternate starting at port 0.
      slv_en = 1'b1; slv_lat = 2; slv_gap = 0;
      push_burst(0, 24'h000100, 8'd1, 1'b0, '0, 1'b1);
      push_burst(1, 24'h000200, 8'd2, 1'b0, '0, 1'b1);
      push_burst(0, 24'h000110, 8'd0, 1'b0, '0, 1'b1);
      push_burst(1, 24'h000210, 8'd1, 1'b0, '0, 1'b1);
      push_burst(0, 24'h000120, 8'd3, 1'b0, '0, 1'b1);
      push_burst(1, 24'h000220, 8'd0, 1'b0, '0, 1'b1);
      wait_drain("rr", 500);

      // Single port-0 read, len=3, streaming acks; then an address-wrapping burst.
      push_burst(0, 24'h001000, 8'd3, 1'b0, '0, 1'b1);
      wait_drain("p0", 200);
      chk("p0_gnt_cycles", 64'(g0_len), 64'(5));
      push_burst(0, 24'hFFFFFE, 8'd3, 1'b0, '0, 1'b1);
      wait_drain("wrap", 200);
      chk("wrap_gnt_cycles", 64'(g0_len), 64'(5));

      // Starvation guard: urgent display gets 4 bursts, then the writer.
      req0_urgent = 1'b1;
      for (int i = 0; i < 4; i++) push_burst(0, 24'h002000 + AW'(16 * i), 8'd1, 1'b0, '0, 1'b1);
      push_burst(1, 24'h003000, 8'd1, 1'b0, '0, 1'b1);
      push_burst(0, 24'h002100, 8'd0, 1'b0, '0, 1'b1);
      wait_drain("starve", 800);
      req0_urgent = 1'b0;

      // Slow write burst on port 1: write data must follow each ack.
      slv_lat = 10; slv_gap = 10;
      push_burst(1, 24'h004000, 8'd1, 1'b1, 32'hCAFE_0000, 1'b1);
      wait_drain("write", 300);

      // Timeout: no ack ever, burst aborted after 255 busy cycles.
      slv_en = 1'b0;
      push_burst(0, 24'h005000, 8'd0, 1'b0, '0, 1'b0);
      n = 0;
      while (err0_cnt == 0 && n < 600) begin @(negedge pixel_clk); n++; end
      chk("tmo_seen", 64'(err0_cnt), 64'(1));
      chk("tmo_cycles", 64'(err0_cyc), 64'(255));
      chk("tmo_cyc_low", 64'(err0_wbcyc), 64'(0));
      slv_en = 1'b1; slv_lat = 2; slv_gap = 0;
      push_burst(1, 24'h005100, 8'd1, 1'b0, '0, 1'b1);
      wait_drain("after_tmo", 200);
      chk("tmo_single", 64'(err0_cnt), 64'(1));

      // Reset in the middle of a burst, then a tie resolved toward port 0 again.
      slv_lat = 10; slv_gap = 10;
      push_burst(0, 24'h006000, 8'd7, 1'b0, '0, 1'b1);
      n = 0;
      while (!req0_gnt && n < 50) begin @(negedge pixel_clk); n++; end
      chk("mid_gnt", 64'(req0_gnt), 64'(1));
      repeat (25) @(negedge pixel_clk);
      #2 pixel_rst_n = 1'b0;
      #1;
      chk("mid_rst_bus", 64'({req1_gnt, req0_gnt, wb_cyc, wb_stb, wb_we, wb_adr}), 64'(0));
      chk("mid_rst_data", 64'({rdat, wb_dat_o}), 64'(0));
      chk("mid_rst_pulses", 64'({req1_ack, req0_ack, req1_done, req0_done, req1_err, req0_err}), 64'(0));
      rq0.delete(); rq1.delete(); exp_q.delete(); ack_q.delete();
      repeat (3) @(negedge pixel_clk);
      pixel_rst_n = 1'b1;
      slv_lat = 2; slv_gap = 0;
      push_burst(0, 24'h007000, 8'd1, 1'b0, '0, 1'b1);
      push_burst(1, 24'h008000, 8'd1, 1'b0, '0, 1'b1);
      wait_drain("post_rst", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
